// File: rtl/alu_arb_if.sv
// rtl/alu_arb_if.sv - request/response and shared-ALU signal bundle for alu_arb
interface alu_arb_if;
  logic [1:0]  REQ_VALID;
  logic [1:0]  REQ_READY;
  logic [5:0]  REQ_AR;
  logic [15:0] REQ_AC;
  logic [15:0] REQ_BUS;
  logic [1:0]  RSP_VALID;
  logic [1:0]  RSP_READY;
  logic [7:0]  RSP_DATA;
  logic        RSP_ZERO;
  logic [2:0]  ALU_AR;
  logic [7:0]  ALU_AC;
  logic [7:0]  ALU_BUS;
  logic [7:0]  ALU_IN;
  logic        ALU_CO;
  logic        BUSY;

  modport slave (
    input  REQ_VALID, REQ_AR, REQ_AC, REQ_BUS, RSP_READY, ALU_IN, ALU_CO,
    output REQ_READY, RSP_VALID, RSP_DATA, RSP_ZERO, ALU_AR, ALU_AC, ALU_BUS, BUSY
  );

  modport master (
    output REQ_VALID, REQ_AR, REQ_AC, REQ_BUS, RSP_READY, ALU_IN, ALU_CO,
    input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ZERO, ALU_AR, ALU_AC, ALU_BUS, BUSY
  );
endinterface

// File: rtl/alu_arb.sv
// rtl/alu_arb.sv - two-requester arbiter/sequencer for the shared 8-bit ALU
module alu_arb #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input logic       CLK,
  input logic       nRST,
  alu_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic [2:0]  alu_ar_q, alu_ar_d;
  logic [7:0]  alu_ac_q, alu_ac_d;
  logic [7:0]  alu_bus_q, alu_bus_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_zero_q, rsp_zero_d;

  logic        gnt_idx;
  logic        accept;
  logic        rsp_take;

  // last_q resets to 1 so requester 0 wins the first contention
  always_comb begin
    gnt_idx = 1'b0;
    case (bus.REQ_VALID)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = PRIO_FIXED ? 1'b0 : ~last_q;
      default: gnt_idx = 1'b0;
    endcase
  end

  assign accept        = (state_q == IDLE) && (|bus.REQ_VALID);
  assign rsp_take      = bus.RSP_READY[owner_q];
  assign bus.REQ_READY = accept ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    alu_ar_d   = alu_ar_q;
    alu_ac_d   = alu_ac_q;
    alu_bus_d  = alu_bus_q;
    rsp_data_d = rsp_data_q;
    rsp_zero_d = rsp_zero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = ISSUE;
          owner_d   = gnt_idx;
          last_d    = gnt_idx;
          alu_ar_d  = gnt_idx ? bus.REQ_AR[5:3]   : bus.REQ_AR[2:0];
          alu_ac_d  = gnt_idx ? bus.REQ_AC[15:8]  : bus.REQ_AC[7:0];
          alu_bus_d = gnt_idx ? bus.REQ_BUS[15:8] : bus.REQ_BUS[7:0];
        end
      end
      ISSUE: begin
        state_d    = RESP;
        rsp_data_d = bus.ALU_IN;
        rsp_zero_d = bus.ALU_CO;
      end
      RESP: begin
        if (rsp_take) begin
          state_d   = IDLE;
          alu_ar_d  = 3'd0;
          alu_ac_d  = 8'd0;
          alu_bus_d = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      alu_ar_q   <= 3'd0;
      alu_ac_q   <= 8'd0;
      alu_bus_q  <= 8'd0;
      rsp_data_q <= 8'd0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      alu_ar_q   <= alu_ar_d;
      alu_ac_q   <= alu_ac_d;
      alu_bus_q  <= alu_bus_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end

  assign bus.RSP_VALID = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.RSP_DATA  = rsp_data_q;
  assign bus.RSP_ZERO  = rsp_zero_q;
  assign bus.ALU_AR    = alu_ar_q;
  assign bus.ALU_AC    = alu_ac_q;
  assign bus.ALU_BUS   = alu_bus_q;
  assign bus.BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arb.sv
// tb/tb_alu_arb.sv - directed bench for alu_arb, round-robin and fixed-priority instances
module tb_alu_arb;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [5:0]  req_ar;
  logic [15:0] req_ac;
  logic [15:0] req_bus;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  alu_arb_if ifa ();
  alu_arb_if ifb ();

  function automatic logic [8:0] alu_model(input logic [2:0] ar, input logic [7:0] ac,
                                           input logic [7:0] bs);
    logic [7:0] r;
    case (ar)
      3'd0: r = bs;
      3'd1: r = ac & bs;
      3'd2: r = ac | bs;
      3'd3: r = ac ^ bs;
      3'd4: r = ac + bs;
      3'd5: r = ac - bs;
      3'd6: r = ac;
      default: r = 8'd0 - ac;
    endcase
    return {(r == 8'd0), r};
  endfunction

  assign ifa.REQ_VALID = req_valid;
  assign ifa.REQ_AR    = req_ar;
  assign ifa.REQ_AC    = req_ac;
  assign ifa.REQ_BUS   = req_bus;
  assign ifa.RSP_READY = rsp_ready;
  assign {ifa.ALU_CO, ifa.ALU_IN} = alu_model(ifa.ALU_AR, ifa.ALU_AC, ifa.ALU_BUS);

  assign ifb.REQ_VALID = req_valid;
  assign ifb.REQ_AR    = req_ar;
  assign ifb.REQ_AC    = req_ac;
  assign ifb.REQ_BUS   = req_bus;
  assign ifb.RSP_READY = rsp_ready;
  assign {ifb.ALU_CO, ifb.ALU_IN} = alu_model(ifb.ALU_AR, ifb.ALU_AC, ifb.ALU_BUS);

  alu_arb #(.PRIO_FIXED(1'b0)) u_rr (.CLK(CLK), .nRST(nRST), .bus(ifa.slave));
  alu_arb #(.PRIO_FIXED(1'b1)) u_fx (.CLK(CLK), .nRST(nRST), .bus(ifb.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [2:0] ar, input logic [7:0] ac,
                         input logic [7:0] bs);
    req_ar[3*idx +: 3]  = ar;
    req_ac[8*idx +: 8]  = ac;
    req_bus[8*idx +: 8] = bs;
  endtask

  // starts and ends between a negedge and the following posedge with the DUT idle
  task automatic single_op(input string tag, input int idx, input logic [2:0] ar,
                           input logic [7:0] ac, input logic [7:0] bs,
                           input logic [7:0] exp_d, input logic exp_z);
    logic [1:0] onehot;
    onehot = (idx == 1) ? 2'b10 : 2'b01;
    req_valid = 2'b00;
    set_req(idx, ar, ac, bs);
    req_valid = onehot;
    rsp_ready = 2'b11;
    #1;
    check({tag, "_req_ready"}, 32'(ifa.REQ_READY), 32'(onehot));
    check({tag, "_busy_idle"}, 32'(ifa.BUSY), 32'd0);
    @(negedge CLK);
    req_valid = 2'b00;
    #1;
    check({tag, "_busy_issue"}, 32'(ifa.BUSY), 32'd1);
    check({tag, "_alu_ar"}, 32'(ifa.ALU_AR), 32'(ar));
    check({tag, "_alu_ac"}, 32'(ifa.ALU_AC), 32'(ac));
    check({tag, "_alu_bus"}, 32'(ifa.ALU_BUS), 32'(bs));
    check({tag, "_rsp_valid_issue"}, 32'(ifa.RSP_VALID), 32'd0);
    @(negedge CLK);
    #1;
    check({tag, "_rsp_valid"}, 32'(ifa.RSP_VALID), 32'(onehot));
    check({tag, "_rsp_data"}, 32'(ifa.RSP_DATA), 32'(exp_d));
    check({tag, "_rsp_zero"}, 32'(ifa.RSP_ZERO), 32'(exp_z));
    check({tag, "_busy_resp"}, 32'(ifa.BUSY), 32'd1);
    @(negedge CLK);
    #1;
    check({tag, "_busy_done"}, 32'(ifa.BUSY), 32'd0);
    check({tag, "_alu_ar_clr"}, 32'(ifa.ALU_AR), 32'd0);
    check({tag, "_rsp_valid_done"}, 32'(ifa.RSP_VALID), 32'd0);
  endtask

  task automatic reset_pulse();
    nRST = 1'b0;
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    nRST      = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_ar    = '0;
    req_ac    = '0;
    req_bus   = '0;

    @(negedge CLK);
    #1;
    check("rst_rsp_valid", 32'(ifa.RSP_VALID), 32'd0);
    check("rst_rsp_data", 32'(ifa.RSP_DATA), 32'd0);
    check("rst_rsp_zero", 32'(ifa.RSP_ZERO), 32'd0);
    check("rst_alu_ar", 32'(ifa.ALU_AR), 32'd0);
    check("rst_busy", 32'(ifa.BUSY), 32'd0);
    check("rst_req_ready", 32'(ifa.REQ_READY), 32'd0);
    nRST = 1'b1;

    single_op("add0", 0, 3'd4, 8'h7F, 8'h01, 8'h80, 1'b0);
    single_op("sub1", 1, 3'd5, 8'h05, 8'h05, 8'h00, 1'b1);
    single_op("neg1", 1, 3'd7, 8'h01, 8'h00, 8'hFF, 1'b0);

    // contention from a fresh reset: round-robin alternates, fixed priority keeps 0
    reset_pulse();
    set_req(0, 3'd3, 8'hF0, 8'h0F);
    set_req(1, 3'd1, 8'hF0, 8'h0F);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_grant", 32'(ifa.REQ_READY), (k % 2 == 0) ? 32'h1 : 32'h2);
      check("fx_grant", 32'(ifb.REQ_READY), 32'h1);
      @(negedge CLK);
      @(negedge CLK);
      #1;
      check("rr_rsp_valid", 32'(ifa.RSP_VALID), (k % 2 == 0) ? 32'h1 : 32'h2);
      check("rr_rsp_data", 32'(ifa.RSP_DATA), (k % 2 == 0) ? 32'hFF : 32'h00);
      check("rr_rsp_zero", 32'(ifa.RSP_ZERO), (k % 2 == 0) ? 32'h0 : 32'h1);
      check("fx_rsp_valid", 32'(ifb.RSP_VALID), 32'h1);
      check("fx_rsp_data", 32'(ifb.RSP_DATA), 32'hFF);
      @(negedge CLK);
    end
    req_valid = 2'b00;

    // response backpressure with the non-owner's ready pulsing
    set_req(0, 3'd2, 8'h12, 8'h40);
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    @(negedge CLK);
    req_valid = 2'b10;
    @(negedge CLK);
    for (int c = 0; c < 5; c++) begin
      rsp_ready = (c % 2 == 1) ? 2'b10 : 2'b00;
      #1;
      check("bp_rsp_valid", 32'(ifa.RSP_VALID), 32'h1);
      check("bp_rsp_data", 32'(ifa.RSP_DATA), 32'h52);
      check("bp_req_ready", 32'(ifa.REQ_READY), 32'h0);
      check("bp_alu_ar", 32'(ifa.ALU_AR), 32'h2);
      @(negedge CLK);
    end
    rsp_ready = 2'b01;
    req_valid = 2'b00;
    #1;
    check("bp_rsp_valid_last", 32'(ifa.RSP_VALID), 32'h1);
    @(negedge CLK);
    #1;
    check("bp_busy_after", 32'(ifa.BUSY), 32'd0);
    check("bp_rsp_valid_after", 32'(ifa.RSP_VALID), 32'd0);

    // reset while in ISSUE; requester 0 just won so last would otherwise favour 1
    set_req(0, 3'd4, 8'h01, 8'h01);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    @(negedge CLK);
    req_valid = 2'b00;
    #1;
    check("mid_busy_before", 32'(ifa.BUSY), 32'd1);
    nRST = 1'b0;
    #1;
    check("mid_alu_ar", 32'(ifa.ALU_AR), 32'd0);
    check("mid_alu_ac", 32'(ifa.ALU_AC), 32'd0);
    check("mid_alu_bus", 32'(ifa.ALU_BUS), 32'd0);
    check("mid_rsp_valid", 32'(ifa.RSP_VALID), 32'd0);
    check("mid_rsp_data", 32'(ifa.RSP_DATA), 32'd0);
    check("mid_busy", 32'(ifa.BUSY), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("post_rst_rsp_valid", 32'(ifa.RSP_VALID), 32'd0);
      @(negedge CLK);
    end
    set_req(1, 3'd6, 8'h33, 8'h00);
    req_valid = 2'b11;
    #1;
    check("post_rst_grant", 32'(ifa.REQ_READY), 32'h1);
    req_valid = 2'b00;
    @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
